pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage SYS_ processor core. Sits beside the IF/ID/EX/MEM/WB registers and drives their write-enables and flushes. It detects RAW hazards through an internal 2-entry destination scoreboard, since the core has no forwarding. It also squashes wrong-path instructions on taken branches and provides load, single-step and halt-on-exception sequencing.

## Interface
- No parameters; all widths fixed (5-bit register index, 16-bit counters).
- SYS_clk  in  1  core clock; all state updates on rising edge.
- SYS_reset  in  1  asynchronous, active-low reset.
- SYS_load  in  1  PC load request; level-sensitive.
- step_en  in  1  single-step mode enable.
- step_req  in  1  one-cycle pulse; advances the pipeline one cycle when step_en=1.
- id_rs, id_rt  in  5 each  source register indices of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch).
- id_dest  in  5  destination index of ID instruction (post RegDst select).
- id_regwrite  in  1  ID instruction writes a register.
- id_exception  in  1  Exception control bit of ID instruction.
- mem_branch_taken  in  1  Branch_MEM AND ALU zero flag.
- pc_we  out  1  PC register write-enable.
- if_id_we  out  1  IF/ID write-enable.
- pipe_we  out  1  ID/EX, EX/MEM and MEM/WB write-enable.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (all controls 0) into the named register.
- state  out  2  FSM state encoding.
- halted  out  1  state==HALT.
- stall_cnt, flush_cnt  out  16 each  performance counters (see Configuration).

## Operation
- States: IDLE=0, LOAD=1, RUN=2, HALT=3. DRAIN is a RUN sub-mode: drain_cnt != 0.
- IDLE: pc_we=if_id_we=pipe_we=0, all flushes 1.
- LOAD: entered from any state while SYS_load=1.
  - pc_we=1, pipe_we=1, all flushes 1; scoreboard and drain_cnt cleared.
  - Moves to RUN on the first cycle SYS_load=0.
- RUN, advance = (!step_en | step_req).
  - No advance: all write-enables 0, flushes 0, scoreboard frozen.
- Scoreboard entries sb_ex, sb_mem, each {valid, reg}. A hit on an entry requires valid, reg!=0 and (reg==id_rs, or id_uses_rt and reg==id_rt).
- Hazard = hit on sb_ex or sb_mem. On advance with hazard (stall):
  - pc_we=0, if_id_we=0, pipe_we=1, id_ex_flush=1.
  - sb_mem<=sb_ex; sb_ex<=invalid.
- Normal advance:
  - All enables 1.
  - sb_mem<=sb_ex; sb_ex<={id_regwrite, id_dest}.
- Taken branch on advance (mem_branch_taken=1): priority over stall and exception.
  - if_id_flush=id_ex_flush=ex_mem_flush=1, pc_we=1.
  - Both scoreboard entries invalidated; drain_cnt cleared.
- Exception: advance with id_exception=1, no hazard, no branch.
  - ID instruction proceeds; if_id_flush=1; pc_we=0.
  - drain_cnt<=3 (DRAIN mode).
  - In DRAIN, each advance: pc_we=0, if_id_flush=1, drain_cnt decrements; reaching 0 moves to HALT.
  - A taken branch during DRAIN cancels it: drain_cnt=0, stay RUN.
- HALT: same outputs as IDLE; exited only by SYS_load or reset.
- Reset: state=IDLE, scoreboard invalid, drain_cnt=0, counters 0, halted=0.

## Timing
- State, scoreboard and drain_cnt are registered.
- Enable/flush outputs are combinational (Mealy) from registered state plus same-cycle ID/MEM inputs.
- No input-to-state path other than via SYS_clk edge or SYS_reset.
- Register file writes at negedge, so the WB-stage producer needs no stall.
- RAW stall duration:
  - Producer in EX: 2 stall cycles.
  - Producer in MEM: 1 stall cycle.
- Branch penalty: 3 squashed instructions.
- Exception to halted=1: 4 rising edges after the exception is in ID with advance.
- SYS_load=1 with mem_branch_taken=1: LOAD wins.
- step_req while step_en=0: ignored.
- Reset asserted mid-stall or mid-drain: outputs take IDLE values immediately (asynchronous).

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt increments on each stall cycle; flush_cnt increments on each taken-branch flush.
  - Both saturate at 16'hFFFF and clear in LOAD.
- PIPE_CTRL_PERF_EN undefined: no counter registers; stall_cnt and flush_cnt tied to 0.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - State encodings IDLE/LOAD/RUN/HALT.
  - Scoreboard entry typedef {valid, reg[4:0]}.
  - Constant DRAIN_DEPTH=3.
- One sub-module, pipe_hazard_cmp: compares id_rs/id_rt/id_uses_rt against one scoreboard entry and returns hit. Instantiated twice.

## Test plan
- Reset then SYS_load pulse 2 cycles -> IDLE outputs during reset; state=LOAD for 2 cycles, then RUN with all enables 1.
- `lw $2` followed immediately by `add $3,$2,$4` -> 2 cycles with pc_we=0 and id_ex_flush=1, then add advances; stall_cnt=2 with PIPE_CTRL_PERF_EN.
- Producer `$5` followed by one independent instruction, then consumer `$5` -> exactly 1 stall; producer `$0` -> no stall.
- Taken beq reaching MEM while a dependent stall is pending -> three flushes asserted in that cycle with pc_we=1, scoreboard cleared, no stall; flush_cnt=1.
- Exception opcode in ID -> if_id_flush held for 4 cycles, halted=1 on the 4th edge; a later SYS_load returns to RUN.
- step_en=1, no step_req for 5 cycles, then one pulse -> enables 0 for 5 cycles, then exactly one advance cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencing controller.
//   state_e     - controller FSM state encoding (IDLE/LOAD/RUN/HALT)
//   sb_entry_t  - destination scoreboard entry {valid, idx}
//   DRAIN_DEPTH - cycles drained after an exception before halting
package pipe_ctrl_pkg;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned DRAIN_W = 2;
   localparam int unsigned STATE_W = 2;

   localparam logic [DRAIN_W-1:0] DRAIN_DEPTH = DRAIN_W'(3);

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } state_e;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] idx;
   } sb_entry_t;

   localparam sb_entry_t SB_INVALID = '{valid: 1'b0, idx: REG_W'(0)};

endpackage

// File: rtl/pipe_hazard_cmp.sv
// pipe_hazard_cmp: RAW hit detection of the ID instruction against one scoreboard entry.
// Ports:
//   i_rs, i_rt   - source register indices of the ID instruction
//   i_uses_rt    - ID instruction actually reads rt
//   i_entry      - scoreboard entry {valid, idx}
//   o_hit_c      - combinational hit; $0 never hits since it is hard-wired zero
module pipe_hazard_cmp
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] i_rs,
   input  logic [REG_W-1:0] i_rt,
   input  logic             i_uses_rt,
   input  sb_entry_t        i_entry,
   output logic             o_hit_c
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (i_entry.idx == i_rs);
   assign w_rt_match = i_uses_rt && (i_entry.idx == i_rt);
   assign o_hit_c    = i_entry.valid && (i_entry.idx != REG_W'(0)) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage SYS_ core.
// Drives stage-register write-enables and flushes; detects RAW hazards via a
// 2-entry destination scoreboard (no forwarding), squashes wrong-path work on
// taken branches, and sequences load, single-step and halt-on-exception.
// Ports:
//   SYS_clk, SYS_reset (async, active-low)
//   SYS_load, step_en, step_req                    - sequencing controls
//   id_rs, id_rt, id_uses_rt, id_dest, id_regwrite  - ID-stage operand info
//   id_exception, mem_branch_taken                  - exception / branch resolution
//   pc_we, if_id_we, pipe_we                        - stage write-enables (Mealy)
//   if_id_flush, id_ex_flush, ex_mem_flush          - bubble insertion (Mealy)
//   state, halted                                   - FSM state observation
//   stall_cnt, flush_cnt                            - perf counters
// Build option: PIPE_CTRL_PERF_EN enables the saturating perf counters;
// without it the counters read as zero.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic               SYS_clk,
   input  logic               SYS_reset,
   input  logic               SYS_load,
   input  logic               step_en,
   input  logic               step_req,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic               id_uses_rt,
   input  logic [REG_W-1:0]   id_dest,
   input  logic               id_regwrite,
   input  logic               id_exception,
   input  logic               mem_branch_taken,
   output logic               pc_we,
   output logic               if_id_we,
   output logic               pipe_we,
   output logic               if_id_flush,
   output logic               id_ex_flush,
   output logic               ex_mem_flush,
   output logic [STATE_W-1:0] state,
   output logic               halted,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   state_e             r_state;
   state_e             w_state_nxt;
   sb_entry_t          r_sb_ex;
   sb_entry_t          r_sb_mem;
   sb_entry_t          w_sb_ex_nxt;
   sb_entry_t          w_sb_mem_nxt;
   sb_entry_t          w_id_entry;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [DRAIN_W-1:0] w_drain_nxt;
   logic               w_hit_ex;
   logic               w_hit_mem;
   logic               w_hazard;
   logic               w_advance;

   // RAW check against the producers currently in EX and MEM
   pipe_hazard_cmp u_cmp_ex (
      .i_rs      (id_rs),
      .i_rt      (id_rt),
      .i_uses_rt (id_uses_rt),
      .i_entry   (r_sb_ex),
      .o_hit_c   (w_hit_ex)
   );

   pipe_hazard_cmp u_cmp_mem (
      .i_rs      (id_rs),
      .i_rt      (id_rt),
      .i_uses_rt (id_uses_rt),
      .i_entry   (r_sb_mem),
      .o_hit_c   (w_hit_mem)
   );

   assign w_hazard   = w_hit_ex || w_hit_mem;
   assign w_advance  = !step_en || step_req;
   assign w_id_entry = '{valid: id_regwrite, idx: id_dest};

   // State, scoreboard and drain counter registers
   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         r_state     <= IDLE;
         r_sb_ex     <= SB_INVALID;
         r_sb_mem    <= SB_INVALID;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sb_ex     <= w_sb_ex_nxt;
         r_sb_mem    <= w_sb_mem_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   // Next-state and Mealy enable/flush decode
   always_comb begin
      w_state_nxt  = r_state;
      w_sb_ex_nxt  = r_sb_ex;
      w_sb_mem_nxt = r_sb_mem;
      w_drain_nxt  = r_drain_cnt;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      pipe_we      = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;

      case (r_state)
         IDLE, HALT: begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end
         LOAD: begin
            pc_we        = 1'b1;
            pipe_we      = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            w_sb_ex_nxt  = SB_INVALID;
            w_sb_mem_nxt = SB_INVALID;
            w_drain_nxt  = '0;
            w_state_nxt  = RUN;
         end
         RUN: begin
            if (w_advance) begin
               if (mem_branch_taken) begin
                  // Squash IF, ID and EX; wrong-path producers never write back
                  pc_we        = 1'b1;
                  if_id_we     = 1'b1;
                  pipe_we      = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_flush  = 1'b1;
                  ex_mem_flush = 1'b1;
                  w_sb_ex_nxt  = SB_INVALID;
                  w_sb_mem_nxt = SB_INVALID;
                  w_drain_nxt  = '0;
               end else if (r_drain_cnt != '0) begin
                  // Drain older instructions; fetch is frozen and ID gets bubbles
                  if_id_we     = 1'b1;
                  pipe_we      = 1'b1;
                  if_id_flush  = 1'b1;
                  w_sb_mem_nxt = r_sb_ex;
                  w_sb_ex_nxt  = w_id_entry;
                  w_drain_nxt  = r_drain_cnt - DRAIN_W'(1);
                  if (r_drain_cnt == DRAIN_W'(1)) begin
                     w_state_nxt = HALT;
                  end
               end else if (w_hazard) begin
                  // Hold IF/ID, send a bubble into EX
                  pipe_we      = 1'b1;
                  id_ex_flush  = 1'b1;
                  w_sb_mem_nxt = r_sb_ex;
                  w_sb_ex_nxt  = SB_INVALID;
               end else if (id_exception) begin
                  if_id_we     = 1'b1;
                  pipe_we      = 1'b1;
                  if_id_flush  = 1'b1;
                  w_sb_mem_nxt = r_sb_ex;
                  w_sb_ex_nxt  = w_id_entry;
                  w_drain_nxt  = DRAIN_DEPTH;
               end else begin
                  pc_we        = 1'b1;
                  if_id_we     = 1'b1;
                  pipe_we      = 1'b1;
                  w_sb_mem_nxt = r_sb_ex;
                  w_sb_ex_nxt  = w_id_entry;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Load request overrides everything, including a same-cycle taken branch
      if (SYS_load) begin
         w_state_nxt  = LOAD;
         w_sb_ex_nxt  = SB_INVALID;
         w_sb_mem_nxt = SB_INVALID;
         w_drain_nxt  = '0;
      end
   end

   assign state  = r_state;
   assign halted = (r_state == HALT);

`ifdef PIPE_CTRL_PERF_EN
   logic             w_stall_evt;
   logic             w_flush_evt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   assign w_stall_evt = (r_state == RUN) && !SYS_load && w_advance && !mem_branch_taken &&
                        (r_drain_cnt == '0) && w_hazard;
   assign w_flush_evt = (r_state == RUN) && !SYS_load && w_advance && mem_branch_taken;

   // Saturating event counters, cleared while loading
   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (r_state == LOAD) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush_evt && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl.
// Vectors are applied at the falling edge; outputs are sampled 1ns later.
// Output word: {pc_we, if_id_we, pipe_we, if_id_flush, id_ex_flush, ex_mem_flush, state[1:0], halted}
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld, sen, sreq, ut, rw, exc, br;
   logic [4:0]  rs, rt, dst;
   logic        pc_we, if_id_we, pipe_we, if_id_flush, id_ex_flush, ex_mem_flush, halted;
   logic [1:0]  st;
   logic [15:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   localparam logic [8:0] O_N    = 9'b111_000_10_0;
   localparam logic [8:0] O_ST   = 9'b001_010_10_0;
   localparam logic [8:0] O_BR   = 9'b111_111_10_0;
   localparam logic [8:0] O_EX   = 9'b011_100_10_0;
   localparam logic [8:0] O_HOLD = 9'b000_000_10_0;
   localparam logic [8:0] O_IDLE = 9'b000_111_00_0;
   localparam logic [8:0] O_LOAD = 9'b101_111_01_0;
   localparam logic [8:0] O_HALT = 9'b000_111_11_1;

   typedef struct {
      logic        ld, sen, sreq;
      logic [4:0]  rs, rt;
      logic        ut;
      logic [4:0]  dst;
      logic        rw, exc, br, chk;
      logic [8:0]  exp;
      logic [15:0] sc, fc;
   } vec_t;

   typedef struct packed {
      logic [8:0]  o;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   vec_t vt[$];
   exp_t exp_q[$];

   pipe_ctrl dut (
      .SYS_clk          (clk),
      .SYS_reset        (rst_n),
      .SYS_load         (ld),
      .step_en          (sen),
      .step_req         (sreq),
      .id_rs            (rs),
      .id_rt            (rt),
      .id_uses_rt       (ut),
      .id_dest          (dst),
      .id_regwrite      (rw),
      .id_exception     (exc),
      .mem_branch_taken (br),
      .pc_we            (pc_we),
      .if_id_we         (if_id_we),
      .pipe_we          (pipe_we),
      .if_id_flush      (if_id_flush),
      .id_ex_flush      (id_ex_flush),
      .ex_mem_flush     (ex_mem_flush),
      .state            (st),
      .halted           (halted),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {pc_we, if_id_we, pipe_we, if_id_flush, id_ex_flush, ex_mem_flush, st, halted};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic l, input logic se, input logic sr,
                               input logic [4:0] a, input logic [4:0] b, input logic u,
                               input logic [4:0] d, input logic w, input logic e, input logic bt,
                               input logic c, input logic [8:0] x, input int s, input int f);
      vec_t v;
      v.ld = l; v.sen = se; v.sreq = sr; v.rs = a; v.rt = b; v.ut = u; v.dst = d;
      v.rw = w; v.exc = e; v.br = bt; v.chk = c; v.exp = x; v.sc = 16'(s); v.fc = 16'(f);
      vt.push_back(v);
   endfunction

   task automatic apply(input vec_t v, input string nm);
      exp_t e;
      @(negedge clk);
      ld = v.ld; sen = v.sen; sreq = v.sreq; rs = v.rs; rt = v.rt; ut = v.ut;
      dst = v.dst; rw = v.rw; exc = v.exc; br = v.br;
      if (v.chk) begin
`ifdef PIPE_CTRL_PERF_EN
         exp_q.push_back({v.exp, v.sc, v.fc});
`else
         exp_q.push_back({v.exp, 16'h0, 16'h0});
`endif
      end
      #1;
      if (v.chk) begin
         e = exp_q.pop_front();
         check({nm, "_out"},   32'(obs()),     32'(e.o));
         check({nm, "_stall"}, 32'(stall_cnt), 32'(e.sc));
         check({nm, "_flush"}, 32'(flush_cnt), 32'(e.fc));
      end
   endtask

   initial begin
      vec_t h;
      rst_n = 1'b0;
      {ld, sen, sreq, ut, rw, exc, br} = '0;
      rs = '0; rt = '0; dst = '0;

      //        ld se sr rs  rt  ut dst rw ex br chk exp     sc fc
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_IDLE, 0, 0);  // 0 idle after reset
      add(1, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_IDLE, 0, 0);  // 1 load request seen
      add(1, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_LOAD, 0, 0);  // 2 LOAD
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_LOAD, 0, 0);  // 3 LOAD, release
      add(0, 0, 0, 1,  0,  0, 2,  1, 0, 0, 1, O_N,    0, 0);  // 4 lw $2
      add(0, 0, 0, 2,  4,  1, 3,  1, 0, 0, 1, O_ST,   0, 0);  // 5 add $3,$2,$4 stall 1
      add(0, 0, 0, 2,  4,  1, 3,  1, 0, 0, 1, O_ST,   1, 0);  // 6 stall 2
      add(0, 0, 0, 2,  4,  1, 3,  1, 0, 0, 1, O_N,    2, 0);  // 7 add advances
      add(0, 0, 0, 0,  0,  0, 5,  1, 0, 0, 1, O_N,    2, 0);  // 8 producer $5
      add(0, 0, 0, 6,  7,  1, 8,  1, 0, 0, 1, O_N,    2, 0);  // 9 independent
      add(0, 0, 0, 9,  5,  1, 10, 1, 0, 0, 1, O_ST,   2, 0);  // 10 consumer $5 via rt: 1 stall
      add(0, 0, 0, 9,  5,  1, 10, 1, 0, 0, 1, O_N,    3, 0);  // 11 consumer advances
      add(0, 0, 0, 1,  10, 0, 0,  1, 0, 0, 1, O_N,    3, 0);  // 12 rt unused; producer $0
      add(0, 0, 0, 0,  0,  1, 11, 0, 0, 0, 1, O_N,    3, 0);  // 13 reads $0: no stall
      add(0, 0, 0, 11, 0,  0, 12, 1, 0, 0, 1, O_N,    3, 0);  // 14 $11 never written
      add(0, 0, 0, 12, 0,  0, 0,  0, 0, 1, 1, O_BR,   3, 0);  // 15 branch over pending stall
      add(0, 0, 0, 12, 12, 1, 0,  0, 0, 0, 1, O_N,    3, 1);  // 16 scoreboard cleared
      for (int i = 0; i < 5; i++)
         add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 3, 1);  // 17-21 step hold
      add(0, 1, 1, 0,  0,  0, 13, 1, 0, 0, 1, O_N,    3, 1);  // 22 step pulse
      add(0, 0, 1, 0,  0,  0, 0,  0, 0, 0, 1, O_N,    3, 1);  // 23 step_req w/o step_en
      add(0, 0, 0, 0,  0,  0, 0,  0, 1, 0, 1, O_EX,   3, 1);  // 24 exception in ID
      for (int i = 0; i < 3; i++)
         add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_EX,   3, 1);  // 25-27 drain
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_HALT, 3, 1);  // 28 halted
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 1, 1, O_HALT, 3, 1);  // 29 branch ignored in HALT
      add(1, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_HALT, 3, 1);  // 30 reload requested
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_LOAD, 3, 1);  // 31 LOAD
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_N,    0, 0);  // 32 RUN again
      add(0, 0, 0, 0,  0,  0, 0,  0, 1, 0, 1, O_EX,   0, 0);  // 33 exception
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 1, 1, O_BR,   0, 0);  // 34 branch cancels drain
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_N,    0, 1);  // 35 normal, no drain
      add(1, 0, 0, 0,  0,  0, 0,  0, 0, 1, 0, O_N,    0, 1);  // 36 load + branch (unchecked)
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_LOAD, 0, 1);  // 37 LOAD won
      add(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 1, O_N,    0, 0);  // 38 RUN

      // Reset state, including with a load request pending
      repeat (2) @(negedge clk);
      #1 check("reset_out", 32'(obs()), 32'(O_IDLE));
      check("reset_stall", 32'(stall_cnt), 32'h0);
      check("reset_flush", 32'(flush_cnt), 32'h0);
      @(negedge clk);
      ld = 1'b1;
      @(posedge clk);
      #1 check("reset_load_out", 32'(obs()), 32'(O_IDLE));
      @(negedge clk);
      ld = 1'b0;
      rst_n = 1'b1;

      foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

      // Asynchronous reset in the middle of a stall
      h = '{ld:0, sen:0, sreq:0, rs:0, rt:0, ut:0, dst:20, rw:1, exc:0, br:0, chk:1,
            exp:O_N, sc:0, fc:0};
      apply(h, "pre_stall");
      h.rs = 20; h.dst = 21; h.exp = O_ST;
      apply(h, "mid_stall");
      #2 rst_n = 1'b0;
      #1 check("async_rst_out", 32'(obs()), 32'(O_IDLE));
      check("async_rst_stall", 32'(stall_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      h.rs = 0; h.exp = O_IDLE;
      apply(h, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
